// File: rtl/axi_hp_mem_responder.sv
// AXI3 64-bit slave memory responder backed by a dual-port RAM.
// Port A serves the write engine and port B serves the read engine; the two engines run independently.
module axi_hp_mem_responder #(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int unsigned DEPTH_LOG2 = 10
) (
   input  logic        axi_aclk,
   input  logic        axi_areset,
   input  logic [31:0] s_axi_awaddr,
   input  logic [3:0]  s_axi_awlen,
   input  logic [2:0]  s_axi_awsize,
   input  logic [1:0]  s_axi_awburst,
   input  logic [2:0]  s_axi_awprot,
   input  logic [3:0]  s_axi_awcache,
   input  logic        s_axi_awvalid,
   output logic        s_axi_awready,
   input  logic [63:0] s_axi_wdata,
   input  logic [7:0]  s_axi_wstrb,
   input  logic        s_axi_wvalid,
   input  logic        s_axi_wlast,
   output logic        s_axi_wready,
   output logic        s_axi_bvalid,
   output logic [1:0]  s_axi_bresp,
   input  logic        s_axi_bready,
   input  logic [31:0] s_axi_araddr,
   input  logic [3:0]  s_axi_arlen,
   input  logic [2:0]  s_axi_arsize,
   input  logic [1:0]  s_axi_arburst,
   input  logic [2:0]  s_axi_arprot,
   input  logic [3:0]  s_axi_arcache,
   input  logic        s_axi_arvalid,
   output logic        s_axi_arready,
   output logic [63:0] s_axi_rdata,
   output logic [1:0]  s_axi_rresp,
   output logic        s_axi_rlast,
   output logic        s_axi_rvalid,
   input  logic        s_axi_rready
);

   localparam int unsigned Depth = 2 ** DEPTH_LOG2;

   localparam logic [1:0] W_IDLE = 2'd0;
   localparam logic [1:0] W_DATA = 2'd1;
   localparam logic [1:0] W_RESP = 2'd2;

   localparam logic [1:0] R_IDLE  = 2'd0;
   localparam logic [1:0] R_FETCH = 2'd1;
   localparam logic [1:0] R_DATA  = 2'd2;

   localparam logic [1:0] BurstFixed = 2'd0;
   localparam logic [1:0] BurstIncr  = 2'd1;
   localparam logic [1:0] RespSlverr = 2'b10;

   // Addresses are carried with a 33rd bit so an INCR burst running off the top is still caught.
   function automatic logic beat_err(input logic [32:0] a);
      logic [32:0] off;
      off = a - {1'b0, BASE_ADDR};
      return (a < {1'b0, BASE_ADDR}) || ((off >> (DEPTH_LOG2 + 3)) != 33'd0);
   endfunction

   function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [32:0] a);
      logic [32:0] off;
      off = a - {1'b0, BASE_ADDR};
      return off[DEPTH_LOG2+2:3];
   endfunction

   logic unused_inputs;
   assign unused_inputs = ^{s_axi_awprot, s_axi_awcache, s_axi_arprot, s_axi_arcache,
                            s_axi_awaddr[2:0], s_axi_araddr[2:0]};

   // Write engine
   logic [1:0]  wstate_q, wstate_d;
   logic [32:0] waddr_q, waddr_d;
   logic [3:0]  wlen_q, wlen_d;
   logic [3:0]  wcnt_q, wcnt_d;
   logic        wincr_q, wincr_d;
   logic        wberr_q, wberr_d;
   logic        werr_q, werr_d;
   logic        mem_we;
   logic        w_beat_err;
   logic        w_last_beat;

   assign w_beat_err  = wberr_q | beat_err(waddr_q);
   assign w_last_beat = (wcnt_q == wlen_q);

   always_comb begin
      wstate_d = wstate_q;
      waddr_d  = waddr_q;
      wlen_d   = wlen_q;
      wcnt_d   = wcnt_q;
      wincr_d  = wincr_q;
      wberr_d  = wberr_q;
      werr_d   = werr_q;
      mem_we   = 1'b0;
      case (wstate_q)
         W_IDLE: begin
            if (s_axi_awvalid) begin
               waddr_d  = {1'b0, s_axi_awaddr[31:3], 3'b000};
               wlen_d   = s_axi_awlen;
               wincr_d  = (s_axi_awburst == BurstIncr);
               wberr_d  = (s_axi_awsize != 3'd3) ||
                          ((s_axi_awburst != BurstIncr) && (s_axi_awburst != BurstFixed));
               wcnt_d   = 4'd0;
               werr_d   = 1'b0;
               wstate_d = W_DATA;
            end
         end
         W_DATA: begin
            if (s_axi_wvalid) begin
               mem_we = !w_beat_err;
               // Burst length is fixed by awlen; a wlast in the wrong place only taints bresp.
               if (w_beat_err || (s_axi_wlast != w_last_beat)) werr_d = 1'b1;
               wcnt_d = wcnt_q + 4'd1;
               if (wincr_q) waddr_d = waddr_q + 33'd8;
               if (w_last_beat) wstate_d = W_RESP;
            end
         end
         W_RESP: begin
            if (s_axi_bready) wstate_d = W_IDLE;
         end
         default: wstate_d = W_IDLE;
      endcase
   end

   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         wstate_q <= W_IDLE;
         waddr_q  <= 33'd0;
         wlen_q   <= 4'd0;
         wcnt_q   <= 4'd0;
         wincr_q  <= 1'b0;
         wberr_q  <= 1'b0;
         werr_q   <= 1'b0;
      end else begin
         wstate_q <= wstate_d;
         waddr_q  <= waddr_d;
         wlen_q   <= wlen_d;
         wcnt_q   <= wcnt_d;
         wincr_q  <= wincr_d;
         wberr_q  <= wberr_d;
         werr_q   <= werr_d;
      end
   end

   assign s_axi_awready = (wstate_q == W_IDLE);
   assign s_axi_wready  = (wstate_q == W_DATA);
   assign s_axi_bvalid  = (wstate_q == W_RESP);
   assign s_axi_bresp   = (s_axi_bvalid && werr_q) ? RespSlverr : 2'b00;

   // Read engine
   logic [1:0]  rstate_q, rstate_d;
   logic [32:0] raddr_q, raddr_d;
   logic [3:0]  rlen_q, rlen_d;
   logic [3:0]  rcnt_q, rcnt_d;
   logic        rincr_q, rincr_d;
   logic        rberr_q, rberr_d;
   logic        rerr_q, rerr_d;
   logic        rlast_q, rlast_d;
   logic        mem_re;
   logic [63:0] ram_rd_q;

   always_comb begin
      rstate_d = rstate_q;
      raddr_d  = raddr_q;
      rlen_d   = rlen_q;
      rcnt_d   = rcnt_q;
      rincr_d  = rincr_q;
      rberr_d  = rberr_q;
      rerr_d   = rerr_q;
      rlast_d  = rlast_q;
      mem_re   = 1'b0;
      case (rstate_q)
         R_IDLE: begin
            if (s_axi_arvalid) begin
               raddr_d  = {1'b0, s_axi_araddr[31:3], 3'b000};
               rlen_d   = s_axi_arlen;
               rincr_d  = (s_axi_arburst == BurstIncr);
               rberr_d  = (s_axi_arsize != 3'd3) ||
                          ((s_axi_arburst != BurstIncr) && (s_axi_arburst != BurstFixed));
               rcnt_d   = 4'd0;
               rstate_d = R_FETCH;
            end
         end
         R_FETCH: begin
            mem_re   = 1'b1;
            rerr_d   = rberr_q | beat_err(raddr_q);
            rlast_d  = (rcnt_q == rlen_q);
            rstate_d = R_DATA;
         end
         R_DATA: begin
            if (s_axi_rready) begin
               if (rlast_q) begin
                  rstate_d = R_IDLE;
               end else begin
                  rcnt_d   = rcnt_q + 4'd1;
                  if (rincr_q) raddr_d = raddr_q + 33'd8;
                  rstate_d = R_FETCH;
               end
            end
         end
         default: rstate_d = R_IDLE;
      endcase
   end

   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         rstate_q <= R_IDLE;
         raddr_q  <= 33'd0;
         rlen_q   <= 4'd0;
         rcnt_q   <= 4'd0;
         rincr_q  <= 1'b0;
         rberr_q  <= 1'b0;
         rerr_q   <= 1'b0;
         rlast_q  <= 1'b0;
      end else begin
         rstate_q <= rstate_d;
         raddr_q  <= raddr_d;
         rlen_q   <= rlen_d;
         rcnt_q   <= rcnt_d;
         rincr_q  <= rincr_d;
         rberr_q  <= rberr_d;
         rerr_q   <= rerr_d;
         rlast_q  <= rlast_d;
      end
   end

   assign s_axi_arready = (rstate_q == R_IDLE);
   assign s_axi_rvalid  = (rstate_q == R_DATA);
   assign s_axi_rlast   = s_axi_rvalid && rlast_q;
   assign s_axi_rresp   = (s_axi_rvalid && rerr_q) ? RespSlverr : 2'b00;
   assign s_axi_rdata   = (s_axi_rvalid && !rerr_q) ? ram_rd_q : 64'd0;

   // Dual-port RAM; a same-address read and write in one cycle returns the old word.
   logic [63:0]           mem_q [Depth];
   logic [DEPTH_LOG2-1:0] widx;
   logic [DEPTH_LOG2-1:0] ridx;

   assign widx = word_idx(waddr_q);
   assign ridx = word_idx(raddr_q);

   always_ff @(posedge axi_aclk) begin
      if (mem_we) begin
         for (int i = 0; i < 8; i++) begin
            if (s_axi_wstrb[i]) mem_q[widx][8*i +: 8] <= s_axi_wdata[8*i +: 8];
         end
      end
      if (mem_re) ram_rd_q <= mem_q[ridx];
   end

endmodule

// File: tb/tb_axi_hp_mem_responder.sv
// Scoreboard bench for axi_hp_mem_responder: drivers queue expected B/R responses,
// negedge monitors pop and compare on each handshake.
module tb_axi_hp_mem_responder;

   localparam logic [31:0] Base = 32'h4000_0000;
   localparam int unsigned DepthLog2 = 10;

   logic        clk = 1'b0;
   logic        areset;
   logic [31:0] awaddr, araddr;
   logic [3:0]  awlen, arlen;
   logic [2:0]  awsize, arsize;
   logic [1:0]  awburst, arburst;
   logic        awvalid, awready, arvalid, arready;
   logic [63:0] wdata, rdata;
   logic [7:0]  wstrb;
   logic        wvalid, wlast, wready;
   logic        bvalid, bready;
   logic [1:0]  bresp, rresp;
   logic        rlast, rvalid, rready;

   logic rready_hold = 1'b1;
   logic tog_en = 1'b0;
   logic tog_phase = 1'b0;
   int   tog_cnt = 0;
   assign rready = tog_en ? tog_phase : rready_hold;

   always #5 clk = ~clk;

   axi_hp_mem_responder #(
      .BASE_ADDR  (Base),
      .DEPTH_LOG2 (DepthLog2)
   ) dut (
      .axi_aclk      (clk),
      .axi_areset    (areset),
      .s_axi_awaddr  (awaddr),
      .s_axi_awlen   (awlen),
      .s_axi_awsize  (awsize),
      .s_axi_awburst (awburst),
      .s_axi_awprot  (3'd0),
      .s_axi_awcache (4'd0),
      .s_axi_awvalid (awvalid),
      .s_axi_awready (awready),
      .s_axi_wdata   (wdata),
      .s_axi_wstrb   (wstrb),
      .s_axi_wvalid  (wvalid),
      .s_axi_wlast   (wlast),
      .s_axi_wready  (wready),
      .s_axi_bvalid  (bvalid),
      .s_axi_bresp   (bresp),
      .s_axi_bready  (bready),
      .s_axi_araddr  (araddr),
      .s_axi_arlen   (arlen),
      .s_axi_arsize  (arsize),
      .s_axi_arburst (arburst),
      .s_axi_arprot  (3'd0),
      .s_axi_arcache (4'd0),
      .s_axi_arvalid (arvalid),
      .s_axi_arready (arready),
      .s_axi_rdata   (rdata),
      .s_axi_rresp   (rresp),
      .s_axi_rlast   (rlast),
      .s_axi_rvalid  (rvalid),
      .s_axi_rready  (rready)
   );

   typedef struct packed {
      logic [63:0] data;
      logic [1:0]  resp;
      logic        last;
   } rbeat_t;

   rbeat_t      r_exp[$];
   logic [1:0]  b_exp[$];
   int          hs_cyc[$];
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   logic [63:0] wd [16];
   logic [63:0] rd_exp [16];
   logic [1:0]  rd_exp_resp;

   always @(posedge clk) cyc <= cyc + 1;

   always begin
      @(posedge clk);
      #1;
      tog_cnt++;
      if (tog_cnt == 3) begin
         tog_cnt = 0;
         tog_phase = ~tog_phase;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // R monitor: scoreboard compare on handshake, stability check while stalled.
   logic        stall_q = 1'b0;
   logic [63:0] stall_data;
   logic [1:0]  stall_resp;
   logic        stall_last;
   rbeat_t      r_got;

   always @(negedge clk) begin
      if (stall_q) begin
         chk("r_stall_valid", 64'(rvalid), 64'd1);
         chk("r_stall_data", rdata, stall_data);
         chk("r_stall_last", 64'(rlast), 64'(stall_last));
         chk("r_stall_resp", 64'(rresp), 64'(stall_resp));
      end
      stall_q = rvalid && !rready;
      stall_data = rdata;
      stall_resp = rresp;
      stall_last = rlast;
      if (rvalid && rready) begin
         hs_cyc.push_back(cyc);
         n_checks++;
         if (r_exp.size() == 0) begin
            n_fail++;
            $display("FAIL r_unexpected: got data %h last %0b, expected no beat", rdata, rlast);
         end else begin
            n_checks--;
            r_got = r_exp.pop_front();
            chk("r_data", rdata, r_got.data);
            chk("r_resp", 64'(rresp), 64'(r_got.resp));
            chk("r_last", 64'(rlast), 64'(r_got.last));
         end
      end
   end

   always @(negedge clk) begin
      if (bvalid && bready) begin
         if (b_exp.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL b_unexpected: got bresp %0d, expected no response", bresp);
         end else begin
            chk("b_resp", 64'(bresp), 64'(b_exp.pop_front()));
         end
      end
   end

   task automatic do_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                           input logic [2:0] size, input logic [7:0] strb, input int last_beat,
                           input logic [1:0] exp_bresp);
      int t;
      @(posedge clk);
      #1;
      awaddr = addr; awlen = len[3:0]; awburst = burst; awsize = size; awvalid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!awready && t < 100) begin @(negedge clk); t++; end
      chk("aw_accept", 64'(awready), 64'd1);
      @(posedge clk);
      #1;
      awvalid = 1'b0;
      b_exp.push_back(exp_bresp);
      for (int b = 0; b <= len; b++) begin
         wdata = wd[b]; wstrb = strb; wlast = (b == last_beat); wvalid = 1'b1;
         t = 0;
         @(negedge clk);
         while (!wready && t < 100) begin @(negedge clk); t++; end
         if (!wready) chk("w_accept", 64'(wready), 64'd1);
         @(posedge clk);
         #1;
      end
      wvalid = 1'b0; wlast = 1'b0;
      @(negedge clk);
      chk("wready_drop", 64'(wready), 64'd0);
   endtask

   task automatic do_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input logic [2:0] size, input bit chk_lat);
      int t;
      for (int b = 0; b <= len; b++) r_exp.push_back(rbeat_t'{rd_exp[b], rd_exp_resp, b == len});
      @(posedge clk);
      #1;
      araddr = addr; arlen = len[3:0]; arburst = burst; arsize = size; arvalid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!arready && t < 100) begin @(negedge clk); t++; end
      chk("ar_accept", 64'(arready), 64'd1);
      @(posedge clk);
      #1;
      arvalid = 1'b0;
      if (chk_lat) begin
         @(negedge clk);
         chk("ar_lat_fetch", 64'(rvalid), 64'd0);
         @(negedge clk);
         chk("ar_lat_valid", 64'(rvalid), 64'd1);
      end
   endtask

   task automatic drain();
      int t = 0;
      while ((b_exp.size() != 0 || r_exp.size() != 0) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      chk("drain", 64'(b_exp.size() + r_exp.size()), 64'd0);
      repeat (2) @(negedge clk);
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_awready"}, 64'(awready), 64'd1);
      chk({tag, "_arready"}, 64'(arready), 64'd1);
      chk({tag, "_wready"}, 64'(wready), 64'd0);
      chk({tag, "_bvalid"}, 64'(bvalid), 64'd0);
      chk({tag, "_rvalid"}, 64'(rvalid), 64'd0);
      chk({tag, "_rlast"}, 64'(rlast), 64'd0);
      chk({tag, "_bresp"}, 64'(bresp), 64'd0);
      chk({tag, "_rresp"}, 64'(rresp), 64'd0);
      chk({tag, "_rdata"}, rdata, 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected test completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0, t;
      areset = 1'b1;
      awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
      araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
      wdata = '0; wstrb = '0; wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
      rd_exp_resp = 2'd0;
      repeat (3) @(negedge clk);
      chk_idle_outputs("rst");
      areset = 1'b0;
      @(negedge clk);
      chk_idle_outputs("post_rst");

      // 1: single beat write then read back
      wd[0] = 64'h1122334455667788;
      do_write(Base + 32'h10, 0, 2'd1, 3'd3, 8'hFF, 0, 2'd0);
      drain();
      rd_exp[0] = 64'h1122334455667788; rd_exp_resp = 2'd0;
      do_read(Base + 32'h10, 0, 2'd1, 3'd3, 1'b1);
      drain();

      // 2: 16-beat INCR write/read, one beat per 2 cycles
      for (int i = 0; i < 16; i++) wd[i] = 64'(i);
      do_write(Base, 15, 2'd1, 3'd3, 8'hFF, 15, 2'd0);
      drain();
      for (int i = 0; i < 16; i++) rd_exp[i] = 64'(i);
      hs_cyc.delete();
      do_read(Base, 15, 2'd1, 3'd3, 1'b0);
      drain();
      chk("r_beats16", 64'(hs_cyc.size()), 64'd16);
      if (hs_cyc.size() == 16) chk("r_rate", 64'(hs_cyc[15] - hs_cyc[0]), 64'd30);

      // 3: partial strobe
      wd[0] = 64'hFFFF_FFFF_FFFF_FFFF;
      do_write(Base + 32'h100, 0, 2'd1, 3'd3, 8'hFF, 0, 2'd0);
      wd[0] = 64'd0;
      do_write(Base + 32'h100, 0, 2'd1, 3'd3, 8'h0F, 0, 2'd0);
      drain();
      rd_exp[0] = 64'hFFFF_FFFF_0000_0000;
      do_read(Base + 32'h100, 0, 2'd1, 3'd3, 1'b0);
      drain();

      // 4: errors
      wd[0] = 64'hDEAD_BEEF_DEAD_BEEF;
      do_write(Base + 32'h100, 0, 2'd1, 3'd2, 8'hFF, 0, 2'd2);
      drain();
      do_read(Base + 32'h100, 0, 2'd1, 3'd3, 1'b0);
      drain();
      for (int i = 0; i < 4; i++) wd[i] = 64'hA0 + 64'(i);
      do_write(Base + 32'h180, 3, 2'd1, 3'd3, 8'hFF, 1, 2'd2);
      drain();
      rd_exp[0] = 64'd0; rd_exp_resp = 2'd2;
      do_read(Base + 32'h2000, 0, 2'd1, 3'd3, 1'b0);
      drain();
      do_read(Base, 0, 2'd2, 3'd3, 1'b0);
      drain();
      do_read(Base - 32'h8, 0, 2'd1, 3'd3, 1'b0);
      drain();

      // 5a: rready toggling
      rd_exp_resp = 2'd0;
      for (int i = 0; i < 8; i++) rd_exp[i] = 64'(i);
      tog_en = 1'b1;
      do_read(Base, 7, 2'd1, 3'd3, 1'b0);
      drain();
      tog_en = 1'b0;

      // 5b: concurrent write and read to disjoint regions
      for (int i = 0; i < 8; i++) wd[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
      for (int i = 0; i < 8; i++) rd_exp[i] = 64'(i + 8);
      fork
         do_write(Base + 32'h200, 7, 2'd1, 3'd3, 8'hFF, 7, 2'd0);
         do_read(Base + 32'h40, 7, 2'd1, 3'd3, 1'b0);
      join
      drain();
      for (int i = 0; i < 8; i++) rd_exp[i] = wd[i];
      do_read(Base + 32'h200, 7, 2'd1, 3'd3, 1'b0);
      drain();

      // 5c: B backpressure keeps AW closed
      bready = 1'b0;
      wd[0] = 64'h5555_AAAA_5555_AAAA;
      do_write(Base + 32'h300, 0, 2'd1, 3'd3, 8'hFF, 0, 2'd0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bstall_awready", 64'(awready), 64'd0);
         chk("bstall_bvalid", 64'(bvalid), 64'd1);
      end
      @(posedge clk);
      #1;
      bready = 1'b1;
      drain();

      // 6: reset during beat 2 of an 8-beat read
      for (int i = 0; i < 8; i++) rd_exp[i] = 64'(i);
      n0 = hs_cyc.size();
      do_read(Base, 7, 2'd1, 3'd3, 1'b0);
      t = 0;
      while (hs_cyc.size() < n0 + 2 && t < 100) begin @(negedge clk); t++; end
      while (!rvalid && t < 100) begin @(negedge clk); t++; end
      chk("rst_mid_reached", 64'(rvalid), 64'd1);
      #2;
      areset = 1'b1;
      #1;
      chk("rst_mid_rvalid", 64'(rvalid), 64'd0);
      chk("rst_mid_arready", 64'(arready), 64'd1);
      r_exp.delete();
      @(negedge clk);
      #2;
      areset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("post_rst_rvalid", 64'(rvalid), 64'd0);
         chk("post_rst_arready", 64'(arready), 64'd1);
      end
      for (int i = 0; i < 4; i++) rd_exp[i] = 64'(i + 8);
      do_read(Base + 32'h40, 3, 2'd1, 3'd3, 1'b0);
      drain();

      repeat (5) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
